// File: rtl/uart_feature_framer_pkg.sv
// Shared types and constants for the UART feature front end and the classifier.
package uart_feature_framer_pkg;

  localparam int FEAT_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_feature_framer_rx_core.sv
// 8N1 UART receiver: input synchronizer, bit-timing FSM and byte/error pulses.
module uart_rx_core
  import uart_feature_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic [FEAT_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o,
  output logic              idle_o
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]        sync_q;
  logic              rxs;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_q;
  logic [FEAT_W-1:0] shift_q;
  logic [FEAT_W-1:0] byte_q;
  logic              vld_q;
  logic              ferr_q;

  assign rxs          = sync_q[1];
  assign byte_o       = byte_q;
  assign byte_valid_o = vld_q;
  assign frame_err_o  = ferr_q;
  assign idle_o       = (state_q == RX_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rxs) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit recheck rejects short glitches silently.
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[FEAT_W-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rxs) begin
              byte_q <= shift_q;
              vld_q  <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_feature_framer.sv
// Packs NUM_FEAT received UART bytes into one feature vector with a valid/ready
// output register, overrun detection and an inter-byte silence timeout.
module uart_feature_framer
  import uart_feature_framer_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int NUM_FEAT     = 4,
  parameter int IDLE_TO_BITS = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       RsRx,
  output logic [FEAT_W*NUM_FEAT-1:0] feat_vec,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic [FEAT_W-1:0]          rx_byte,
  output logic                       rx_byte_valid,
  output logic                       frame_err,
  output logic                       overrun
);

  localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TO_MAX = IDLE_TO_BITS * CPB;
  localparam int TO_W   = clog2(TO_MAX + 1);
  localparam int IDX_W  = (NUM_FEAT > 1) ? clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TO_MAX);

  logic rx_idle;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) u_core (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (RsRx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (frame_err),
    .idle_o       (rx_idle)
  );

  logic [NUM_FEAT-1:0][FEAT_W-1:0] collect_q;
  logic [NUM_FEAT-1:0][FEAT_W-1:0] frame_d;
  logic [FEAT_W*NUM_FEAT-1:0]      vec_q;
  logic [IDX_W-1:0]                idx_q;
  logic [TO_W-1:0]                 to_q;
  logic                            valid_q;
  logic                            ovr_q;
  logic                            frame_done;

  assign feat_vec   = vec_q;
  assign feat_valid = valid_q;
  assign overrun    = ovr_q;
  assign frame_done = rx_byte_valid && (idx_q == IDX_LAST);

  // The last byte bypasses the collect register so the frame loads with it.
  always_comb begin
    frame_d             = collect_q;
    frame_d[NUM_FEAT-1] = rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collect_q <= '0;
      vec_q     <= '0;
      idx_q     <= '0;
      to_q      <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= 1'b0;

      if (rx_byte_valid || idx_q == '0) to_q <= '0;
      else if (rx_idle && to_q != TO_LIM) to_q <= to_q + 1'b1;

      if (rx_byte_valid) begin
        collect_q[idx_q] <= rx_byte;
        idx_q <= frame_done ? '0 : idx_q + 1'b1;
      end else if (frame_err || to_q == TO_LIM) begin
        idx_q <= '0;
      end

      if (frame_done) begin
        if (!valid_q || feat_ready) begin
          vec_q   <= frame_d;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && feat_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_feature_framer.sv
// Self-checking bench: table rows, hand sequences for the corner cases and a
// randomized byte stream against a packing model.
module tb_uart_feature_framer;
  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RsRx = 1'b1;
  logic        feat_ready = 1'b1;
  logic [31:0] feat_vec;
  logic        feat_valid;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid, frame_err, overrun;

  always #5 clk = ~clk;

  uart_feature_framer #(
    .CLK_FREQ(1000000), .BAUD(100000), .NUM_FEAT(4), .IDLE_TO_BITS(20)
  ) dut (
    .clk(clk), .rst(rst), .RsRx(RsRx),
    .feat_vec(feat_vec), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_rx, n_ferr, n_ovr, n_vcyc, stab_viol, last_rx_cyc;
  logic [7:0]  got_b[$];
  logic [31:0] got_f[$];
  logic        pv_hold = 1'b0;
  logic [31:0] pv_vec;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_byte_valid) begin n_rx++; got_b.push_back(rx_byte); last_rx_cyc = cyc; end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (feat_valid) n_vcyc++;
    if (feat_valid && feat_ready) got_f.push_back(feat_vec);
    if (rst && pv_hold && (!feat_valid || feat_vec !== pv_vec)) stab_viol++;
    pv_hold = rst && feat_valid && !feat_ready;
    pv_vec  = feat_vec;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drive_bit(input logic b);
    RsRx = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    RsRx = 1'b1;
    tick(gap);
  endtask

  task automatic send_frame(input logic [31:0] v);
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], 1'b1, 0);
  endtask

  task automatic clr();
    n_rx = 0; n_ferr = 0; n_ovr = 0; n_vcyc = 0; stab_viol = 0;
    got_b.delete(); got_f.delete();
  endtask

  typedef struct {
    logic [7:0]  b[4];
    logic [3:0]  stop;
    int          exp_nrx;
    int          exp_ferr;
    int          exp_nfr;
    logic [31:0] exp_vec;
  } row_t;

  row_t        tbl[4];
  logic [7:0]  mb;
  logic        ms;
  int          g, idx, eferr, st, d;
  logic [31:0] acc;
  logic [31:0] expf[$];
  logic [7:0]  expb[$];

  initial begin
    tbl[0] = '{'{8'h12, 8'h34, 8'h56, 8'h78}, 4'b1111, 4, 0, 1, 32'h78563412};
    tbl[1] = '{'{8'h00, 8'hFF, 8'h80, 8'h01}, 4'b1111, 4, 0, 1, 32'h0180FF00};
    tbl[2] = '{'{8'hA5, 8'h5A, 8'hC3, 8'h3C}, 4'b1111, 4, 0, 1, 32'h3CC35AA5};
    tbl[3] = '{'{8'h10, 8'h20, 8'h30, 8'h40}, 4'b1101, 3, 1, 0, 32'h0};

    clr();
    tick(3);
    check("rst_feat_valid", feat_valid, 0);
    check("rst_feat_vec", feat_vec, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_pulses", {rx_byte_valid, frame_err, overrun}, 0);
    rst = 1'b1;
    tick(5);

    // Table rows: each ends with enough silence to flush any partial frame.
    for (int r = 0; r < 4; r++) begin
      clr();
      for (int k = 0; k < 4; k++)
        send_byte(tbl[r].b[k], tbl[r].stop[k], tbl[r].stop[k] ? 0 : 2*CPB);
      tick(250);
      check($sformatf("row%0d_nrx", r), n_rx, tbl[r].exp_nrx);
      check($sformatf("row%0d_ferr", r), n_ferr, tbl[r].exp_ferr);
      check($sformatf("row%0d_nframes", r), got_f.size(), tbl[r].exp_nfr);
      check($sformatf("row%0d_valid_cycles", r), n_vcyc, tbl[r].exp_nfr);
      check($sformatf("row%0d_overrun", r), n_ovr, 0);
      if (tbl[r].exp_nfr == 1 && got_f.size() == 1)
        check($sformatf("row%0d_vec", r), got_f[0], tbl[r].exp_vec);
    end

    // Backpressure: second frame is dropped and flagged, first one held.
    clr();
    feat_ready = 1'b0;
    send_frame(32'hDEADBEEF);
    tick(10);
    check("bp_valid_A", feat_valid, 1);
    check("bp_vec_A", feat_vec, 32'hDEADBEEF);
    send_frame(32'h0BADF00D);
    tick(10);
    check("bp_overrun", n_ovr, 1);
    check("bp_vec_held", feat_vec, 32'hDEADBEEF);
    check("bp_no_xfer", got_f.size(), 0);
    feat_ready = 1'b1;
    tick(1);
    check("bp_valid_drop", feat_valid, 0);
    check("bp_xfer_count", got_f.size(), 1);
    if (got_f.size() == 1) check("bp_xfer_vec", got_f[0], 32'hDEADBEEF);
    check("bp_stable", stab_viol, 0);
    tick(20);

    // Framing error restarts packing.
    clr();
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b0, 2*CPB);
    send_frame(32'hDDCCBBAA);
    tick(20);
    check("ferr_count", n_ferr, 1);
    check("ferr_nframes", got_f.size(), 1);
    if (got_f.size() == 1) check("ferr_vec", got_f[0], 32'hDDCCBBAA);

    // Silence timeout discards a partial frame.
    clr();
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    tick(250);
    send_frame(32'hA4A3A2A1);
    tick(20);
    check("to_nrx", n_rx, 6);
    check("to_nframes", got_f.size(), 1);
    if (got_f.size() == 1) check("to_vec", got_f[0], 32'hA4A3A2A1);

    // Start-bit glitch is ignored; next byte lands with the expected latency.
    clr();
    RsRx = 1'b0;
    tick(3);
    RsRx = 1'b1;
    tick(30);
    check("glitch_nrx", n_rx, 0);
    check("glitch_ferr", n_ferr, 0);
    st = cyc + 1;
    send_byte(8'h5A, 1'b1, 20);
    check("glitch_next_nrx", n_rx, 1);
    if (got_b.size() == 1) check("glitch_next_byte", got_b[0], 8'h5A);
    d = last_rx_cyc - st;
    check("latency_window", (d >= 96 && d <= 98), 1);
    tick(250);

    // Randomized stream against a packing model.
    clr();
    idx = 0; eferr = 0; acc = '0;
    expf.delete(); expb.delete();
    for (int i = 0; i < 24; i++) begin
      mb = 8'($urandom);
      ms = ($urandom_range(7) != 0);
      g  = ($urandom_range(5) == 0) ? $urandom_range(240, 280) : $urandom_range(0, 150);
      if (g >= 240) idx = 0;
      tick(g);
      send_byte(mb, ms, ms ? 0 : 2*CPB);
      if (ms) begin
        expb.push_back(mb);
        acc[8*idx +: 8] = mb;
        idx++;
        if (idx == 4) begin expf.push_back(acc); idx = 0; end
      end else begin
        eferr++;
        idx = 0;
      end
    end
    tick(20);
    check("rnd_nbytes", got_b.size(), expb.size());
    check("rnd_nframes", got_f.size(), expf.size());
    check("rnd_ferr", n_ferr, eferr);
    check("rnd_overrun", n_ovr, 0);
    for (int i = 0; i < expb.size() && i < got_b.size(); i++)
      check($sformatf("rnd_byte%0d", i), got_b[i], expb[i]);
    for (int i = 0; i < expf.size() && i < got_f.size(); i++)
      check($sformatf("rnd_frame%0d", i), got_f[i], expf[i]);
    tick(250);

    // Reset mid-byte with a held output frame.
    clr();
    feat_ready = 1'b0;
    send_frame(32'h44332211);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    tick(3);
    check("pre_rst_valid", feat_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", feat_valid, 0);
    check("mid_rst_vec", feat_vec, 0);
    check("mid_rst_rx_byte", rx_byte, 0);
    check("mid_rst_pulses", {rx_byte_valid, frame_err, overrun}, 0);
    tick(3);
    RsRx = 1'b1;
    rst = 1'b1;
    feat_ready = 1'b1;
    tick(20);
    clr();
    send_frame(32'h04030201);
    tick(20);
    check("post_rst_nrx", n_rx, 4);
    check("post_rst_nframes", got_f.size(), 1);
    if (got_f.size() == 1) check("post_rst_vec", got_f[0], 32'h04030201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_feature_framer.md
Name: uart_feature_framer

Overview:
Receive-side front end of the classifier. Deserializes 8N1 UART bytes from RsRx and packs NUM_FEAT consecutive bytes into one feature vector. The vector goes to the random-forest evaluation stage over a valid/ready handshake. Framing errors, inter-byte timeouts and output overruns are detected and flagged as single-cycle pulses.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4)
NUM_FEAT, 4, bytes per feature vector (1..16)
IDLE_TO_BITS, 20, bit periods of line silence that abort a partial frame

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
RsRx  in  1  UART serial input, idle high, asynchronous to clk
feat_vec  out  8*NUM_FEAT  packed features; byte k at bits [8k+7:8k]
feat_valid  out  1  feat_vec holds a complete frame
feat_ready  in  1  downstream accepts the frame
rx_byte  out  8  last good byte (debug)
rx_byte_valid  out  1  one-cycle pulse per good byte
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: a completed frame was dropped because output was full

Behaviour:
- Reset (rst=0, async): all outputs 0; synchronizer flops 1; FSM IDLE; byte index 0; timeout counter 0.
- RsRx input: 2-flop synchronizer. All sampling uses the synchronized value (rxs).
- Receive FSM, with bit counter cnt and data bit index:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, rxs==0 -> DATA, cnt=0; rxs==1 -> IDLE (glitch rejected, no flag).
  - DATA: at cnt==CLKS_PER_BIT-1, sample rxs, shifting LSB first, cnt=0. After the 8th bit -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
    - rxs==1: rx_byte updated and rx_byte_valid pulses.
    - rxs==0: frame_err pulses, byte discarded, byte index forced to 0.
    - Either case -> IDLE.
- Latency: rx_byte_valid fires 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling start edge reaches RsRx (+/-1).
- Packer:
  - Each good byte is written to collect register slot idx, then idx++.
  - On the byte with idx==NUM_FEAT-1, idx wraps to 0 and the frame completes.
  - The completed frame loads into the output register one cycle after that rx_byte_valid.
- Output handshake:
  - Transfer occurs on feat_valid && feat_ready. After a transfer, feat_valid drops the next cycle.
  - feat_vec and feat_valid are stable while feat_valid=1 and feat_ready=0.
  - Frame completes and a transfer happens the same cycle: the new frame loads and feat_valid stays 1.
  - Frame completes while feat_valid=1 and no transfer: the new frame is dropped, the old one is kept, and overrun pulses.
- Timeout:
  - Counter is cleared on every rx_byte_valid and whenever idx==0.
  - It counts only while idx!=0 and the FSM is in IDLE.
  - Reaching IDLE_TO_BITS*CLKS_PER_BIT forces idx=0 and discards the partial frame. No flag is raised.
- Reset mid-byte or mid-frame: the byte in flight and the partial frame are lost. A held output frame is cleared (feat_valid=0).
- Arithmetic: cnt is clog2(CLKS_PER_BIT) bits wide; the timeout counter is clog2(IDLE_TO_BITS*CLKS_PER_BIT+1) bits wide. No wrap is possible within legal ranges.

Decomposition:
- Shared package:
  - RX FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
  - CLKS_PER_BIT derivation.
  - clog2 helper.
  - FEAT_W=8 constant, also used by the classifier.
- Sub-module uart_rx_core: synchronizer, FSM and byte output (rx_byte, rx_byte_valid, frame_err).
- uart_feature_framer instantiates uart_rx_core and adds the packer, output register and timeout.

Test Plan:
Bench settings: CLK_FREQ=1000000, BAUD=100000 (10 clks/bit), NUM_FEAT=4, feat_ready=1 unless noted.
1. Send 0x12,0x34,0x56,0x78 back-to-back -> feat_vec=0x78563412, feat_valid high exactly 1 cycle; four rx_byte_valid pulses; no flags.
2. Hold feat_ready=0 and send frames A then B -> feat_vec=A held stable, overrun pulses once at B completion. Raise feat_ready -> A transfers, feat_valid drops.
3. Send 0x11, then a byte with stop bit=0, then 0xAA,0xBB,0xCC,0xDD -> frame_err pulses once; feat_vec=0xDDCCBBAA.
4. Send 0x01,0x02, idle 250 clks, then 0xA1,0xA2,0xA3,0xA4 -> partial frame discarded; feat_vec=0xA4A3A2A1.
5. Drive a 3-clk low glitch on RsRx -> no rx_byte_valid, FSM returns to IDLE. A following 0x5A is received correctly.
6. Assert rst low mid-DATA of byte 3 -> all outputs 0 immediately. After release, a full 4-byte frame 0x04030201 is received correctly.
